usb_wire_resolver: RTL and testbench

//  Cycle-based model of a shared USB D+/D- wire for co-simulation. N_PORTS endpoints
//  (host and slave cores) drive or release the wire. Resolves the line from drivers and

---
 rtl/usb_wire_pkg.sv | 24 ++
 rtl/usb_wire_resolver_if.sv | 40 ++++
 rtl/usb_line_debounce.sv | 28 ++
 rtl/usb_wire_resolver.sv | 179 +++++++++++++++++
 tb/tb_usb_wire_resolver.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_wire_pkg.sv
// Shared line codes, FSM state type and helpers for the USB wire resolver.
package usb_wire_pkg;

  localparam logic [1:0] LS_SE0  = 2'b00;
  localparam logic [1:0] LS_K_FS = 2'b01;
  localparam logic [1:0] LS_J_FS = 2'b10;
  localparam logic [1:0] LS_SE1  = 2'b11;

  typedef enum logic [1:0] {
    DETACHED,
    ATTACH_WAIT,
    ATTACHED,
    BUS_RESET
  } wire_state_e;

  // Counts set bits of up to eight endpoint enables.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/usb_wire_resolver_if.sv
// Endpoint-side bundle of the shared USB wire. The contention log signals
// exist only when USB_CONTENTION_LOG_EN is defined.
interface usb_wire_resolver_if #(parameter int N_PORTS = 2);
  logic [2*N_PORTS-1:0] drv_data_i;
  logic [N_PORTS-1:0]   drv_en_i;
  logic [N_PORTS-1:0]   dp_pullup_i;
  logic [N_PORTS-1:0]   dm_pullup_i;
  logic                 clr_contention_i;
  logic [1:0]           line_o;
  logic                 connected_o;
  logic                 full_speed_o;
  logic                 attach_evt_o;
  logic                 detach_evt_o;
  logic                 bus_reset_o;
  logic                 contention_o;
  logic                 config_err_o;
`ifdef USB_CONTENTION_LOG_EN
  localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  logic [15:0]          contention_cnt_o;
  logic [PORT_W-1:0]    contention_port_o;
`endif

  modport master (
`ifdef USB_CONTENTION_LOG_EN
    input  contention_cnt_o, contention_port_o,
`endif
    output drv_data_i, drv_en_i, dp_pullup_i, dm_pullup_i, clr_contention_i,
    input  line_o, connected_o, full_speed_o, attach_evt_o, detach_evt_o,
    input  bus_reset_o, contention_o, config_err_o
  );

  modport slave (
`ifdef USB_CONTENTION_LOG_EN
    output contention_cnt_o, contention_port_o,
`endif
    input  drv_data_i, drv_en_i, dp_pullup_i, dm_pullup_i, clr_contention_i,
    output line_o, connected_o, full_speed_o, attach_evt_o, detach_evt_o,
    output bus_reset_o, contention_o, config_err_o
  );
endinterface

// File: rtl/usb_line_debounce.sv
// Saturating run-length counter: restart_i starts a new run, en_i counts one
// observation, hit_o flags that this observation reaches tc_i.
module usb_line_debounce #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             restart_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             hit_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = restart_i ? '0 : cnt_q;
    cnt_d = base;
    if (en_i && (base != '1)) cnt_d = base + 1'b1;
    hit_o = en_i && (cnt_d >= tc_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
endmodule

// File: rtl/usb_wire_resolver.sv
// Shared USB D+/D- wire: resolves drivers and pullups, registers the line and
// debounces attach/detach/bus reset. USB_CONTENTION_LOG_EN adds a contention log.
module usb_wire_resolver
  import usb_wire_pkg::*;
#(
  parameter int N_PORTS       = 2,
  parameter int ATTACH_CYCLES = 100,
  parameter int DETACH_CYCLES = 100,
  parameter int RESET_CYCLES  = 480,
  parameter int CNT_W         = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  usb_wire_resolver_if.slave bus
);
  localparam logic [CNT_W-1:0] ATT_TC = CNT_W'(ATTACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DET_TC = CNT_W'(DETACH_CYCLES);
  localparam logic [CNT_W-1:0] RST_TC = CNT_W'(RESET_CYCLES);

  logic [3:0] n_drv;
  logic [1:0] masked [N_PORTS];
  logic [1:0] sel_data, line_d;
  logic       dp_any, dm_any, cont_set, cfg_set;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_mask
    assign masked[gi] = bus.drv_en_i[gi] ? bus.drv_data_i[2*gi +: 2] : LS_SE0;
  end

  always_comb begin
    n_drv    = popcount8(8'(bus.drv_en_i));
    dp_any   = |bus.dp_pullup_i;
    dm_any   = |bus.dm_pullup_i;
    sel_data = LS_SE0;
    for (int p = 0; p < N_PORTS; p++) sel_data = sel_data | masked[p];
    if (n_drv == 4'd0)      line_d = {dp_any, dm_any};
    else if (n_drv == 4'd1) line_d = sel_data;
    else                    line_d = LS_SE0;
    cont_set = n_drv > 4'd1;
    cfg_set  = (n_drv == 4'd0) && dp_any && dm_any;
  end

  logic [1:0] line_q, j_q;
  logic       drv_q, kind_q, contention_q, config_err_q;

  // Set beats clear on the sticky flags.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      line_q       <= LS_SE0;
      j_q          <= LS_K_FS;
      drv_q        <= 1'b0;
      kind_q       <= 1'b0;
      contention_q <= 1'b0;
      config_err_q <= 1'b0;
    end else begin
      line_q       <= line_d;
      j_q          <= dp_any ? LS_J_FS : LS_K_FS;
      drv_q        <= n_drv != 4'd0;
      kind_q       <= drv_q;
      contention_q <= cont_set | (contention_q & ~bus.clr_contention_i);
      config_err_q <= cfg_set | (config_err_q & ~bus.clr_contention_i);
    end
  end

  wire_state_e      state_q;
  logic             undrv_j, se0, run_en, run_restart, run_hit;
  logic [CNT_W-1:0] run_tc;
  logic             connected_q, full_speed_q, attach_q, detach_q, bus_reset_q;

  assign undrv_j = !drv_q && (line_q == j_q);
  assign se0     = line_q == LS_SE0;

  // A run of SE0 restarts whenever it switches between driven and undriven.
  always_comb begin
    run_en      = 1'b0;
    run_restart = 1'b1;
    run_tc      = ATT_TC;
    case (state_q)
      ATTACH_WAIT: begin
        run_en      = undrv_j;
        run_restart = !undrv_j;
      end
      ATTACHED: begin
        run_en      = se0;
        run_restart = !se0 || (drv_q != kind_q);
        run_tc      = drv_q ? RST_TC : DET_TC;
      end
      default: ;
    endcase
  end

  usb_line_debounce #(.CNT_W(CNT_W)) u_debounce (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (run_hit),
    .restart_i(run_restart),
    .en_i     (run_en),
    .tc_i     (run_tc),
    .hit_o    (run_hit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= DETACHED;
      connected_q  <= 1'b0;
      full_speed_q <= 1'b0;
      attach_q     <= 1'b0;
      detach_q     <= 1'b0;
      bus_reset_q  <= 1'b0;
    end else begin
      attach_q    <= 1'b0;
      detach_q    <= 1'b0;
      bus_reset_q <= 1'b0;
      case (state_q)
        DETACHED: if (undrv_j) state_q <= ATTACH_WAIT;
        ATTACH_WAIT: begin
          if (run_hit) begin
            state_q      <= ATTACHED;
            attach_q     <= 1'b1;
            connected_q  <= 1'b1;
            full_speed_q <= j_q == LS_J_FS;
          end else if (!undrv_j) begin
            state_q <= DETACHED;
          end
        end
        ATTACHED: begin
          if (run_hit && !drv_q) begin
            state_q      <= DETACHED;
            detach_q     <= 1'b1;
            connected_q  <= 1'b0;
            full_speed_q <= 1'b0;
          end else if (run_hit) begin
            state_q     <= BUS_RESET;
            bus_reset_q <= 1'b1;
          end
        end
        BUS_RESET: if (!se0) state_q <= ATTACHED;
        default: state_q <= DETACHED;
      endcase
    end
  end

`ifdef USB_CONTENTION_LOG_EN
  localparam int PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  logic [15:0]       ccnt_q;
  logic [PORT_W-1:0] cport_q, low_idx;

  always_comb begin
    low_idx = '0;
    for (int p = N_PORTS - 1; p >= 0; p--)
      if (bus.drv_en_i[p]) low_idx = PORT_W'(p);
  end

  // The port is captured only on the first contention cycle after a clear.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ccnt_q  <= '0;
      cport_q <= '0;
    end else if (bus.clr_contention_i) begin
      ccnt_q  <= cont_set ? 16'd1 : 16'd0;
      cport_q <= cont_set ? low_idx : '0;
    end else if (cont_set) begin
      if (ccnt_q != '1) ccnt_q <= ccnt_q + 16'd1;
      if (!contention_q) cport_q <= low_idx;
    end
  end

  assign bus.contention_cnt_o  = ccnt_q;
  assign bus.contention_port_o = cport_q;
`endif

  assign bus.line_o       = line_q;
  assign bus.connected_o  = connected_q;
  assign bus.full_speed_o = full_speed_q;
  assign bus.attach_evt_o = attach_q;
  assign bus.detach_evt_o = detach_q;
  assign bus.bus_reset_o  = bus_reset_q;
  assign bus.contention_o = contention_q;
  assign bus.config_err_o = config_err_q;
endmodule

// File: tb/tb_usb_wire_resolver.sv
// Self-checking bench for usb_wire_resolver: vector table, hand sequences and
// random segments compared against a behavioural wire model.
module tb_usb_wire_resolver;
`ifdef USB_CONTENTION_LOG_EN
  localparam int NP = 4;
`else
  localparam int NP = 2;
`endif
  localparam int ATT = 100;
  localparam int DET = 100;
  localparam int RST = 480;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  usb_wire_resolver_if #(.N_PORTS(NP)) bus ();

  usb_wire_resolver #(
    .N_PORTS(NP), .ATTACH_CYCLES(ATT), .DETACH_CYCLES(DET),
    .RESET_CYCLES(RST), .CNT_W(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 detached, 1 waiting for attach, 2 attached, 3 in bus reset.
  logic [1:0] m_line, m_j;
  bit         m_drv, m_conn, m_fs, m_att, m_det, m_brst, m_cont, m_cfg, m_run_drv;
  int         m_mode, m_run, m_ccnt, m_cport;

  task automatic model_step();
    int n, low;
    bit ujn, se0, dp_any, dm_any;
    m_att = 0; m_det = 0; m_brst = 0;
    if (rst_n !== 1'b1) begin
      m_line = 2'b00; m_j = 2'b01; m_drv = 0; m_mode = 0; m_run = 0;
      m_conn = 0; m_fs = 0; m_cont = 0; m_cfg = 0; m_ccnt = 0; m_cport = 0;
      return;
    end
    ujn = !m_drv && (m_line == m_j);
    se0 = (m_line == 2'b00);
    case (m_mode)
      0: if (ujn) begin m_mode = 1; m_run = 0; end
      1: begin
        if (!ujn) begin
          m_mode = 0; m_run = 0;
        end else begin
          m_run++;
          if (m_run >= ATT - 1) begin
            m_mode = 2; m_run = 0; m_att = 1; m_conn = 1; m_fs = (m_j == 2'b10);
          end
        end
      end
      2: begin
        if (!se0) m_run = 0;
        else begin
          if (m_run > 0 && m_run_drv == m_drv) m_run++;
          else begin m_run = 1; m_run_drv = m_drv; end
          if (!m_drv && m_run >= DET) begin
            m_mode = 0; m_run = 0; m_det = 1; m_conn = 0; m_fs = 0;
          end else if (m_drv && m_run >= RST) begin
            m_mode = 3; m_run = 0; m_brst = 1;
          end
        end
      end
      default: if (!se0) m_mode = 2;
    endcase
    n = $countones(bus.drv_en_i);
    low = -1;
    for (int p = NP - 1; p >= 0; p--) if (bus.drv_en_i[p]) low = p;
    dp_any = |bus.dp_pullup_i;
    dm_any = |bus.dm_pullup_i;
    if (bus.clr_contention_i) begin m_cont = 0; m_cfg = 0; m_ccnt = 0; m_cport = 0; end
    if (n >= 2) begin
      if (!m_cont) m_cport = low;
      m_cont = 1;
      if (m_ccnt < 65535) m_ccnt++;
    end
    if (n == 0 && dp_any && dm_any) m_cfg = 1;
    if (n == 0)      m_line = {dp_any, dm_any};
    else if (n == 1) m_line = bus.drv_data_i[2*low +: 2];
    else             m_line = 2'b00;
    m_drv = (n > 0);
    m_j   = dp_any ? 2'b10 : 2'b01;
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.line_o, bus.connected_o, bus.full_speed_o, bus.attach_evt_o,
            bus.detach_evt_o, bus.bus_reset_o, bus.contention_o, bus.config_err_o};
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_line, m_conn, m_fs, m_att, m_det, m_brst, m_cont, m_cfg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] en, input logic [15:0] data,
                        input logic [7:0] dp, input logic [7:0] dm, input bit clr);
    bus.drv_en_i         = en[NP-1:0];
    bus.drv_data_i       = data[2*NP-1:0];
    bus.dp_pullup_i      = dp[NP-1:0];
    bus.dm_pullup_i      = dm[NP-1:0];
    bus.clr_contention_i = clr;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(8'h0, 16'h0, 8'h0, 8'h0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  en;
    logic [15:0] data;
    logic [7:0]  dp;
    logic [7:0]  dm;
    bit          clr;
    logic [1:0]  line;
    bit          cont;
    bit          cfg;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cnt, idx, cnt2;
    logic [7:0] en_r, dp_r, dm_r;
    logic [15:0] dat_r;

    tbl[0]  = '{8'h0, 16'h0, 8'h0, 8'h0, 1'b1, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{8'h1, 16'h2, 8'h0, 8'h0, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[2]  = '{8'h2, 16'h4, 8'h0, 8'h0, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[3]  = '{8'h0, 16'h0, 8'h2, 8'h0, 1'b0, 2'b10, 1'b0, 1'b0};
    tbl[4]  = '{8'h0, 16'h0, 8'h0, 8'h1, 1'b0, 2'b01, 1'b0, 1'b0};
    tbl[5]  = '{8'h0, 16'h0, 8'h0, 8'h0, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[6]  = '{8'h3, 16'h9, 8'h0, 8'h0, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{8'h0, 16'h0, 8'h1, 8'h0, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[8]  = '{8'h0, 16'h0, 8'h1, 8'h0, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[9]  = '{8'h0, 16'h0, 8'h1, 8'h2, 1'b0, 2'b11, 1'b0, 1'b1};
    tbl[10] = '{8'h0, 16'h0, 8'h1, 8'h2, 1'b1, 2'b11, 1'b0, 1'b1};
    tbl[11] = '{8'h0, 16'h0, 8'h1, 8'h0, 1'b1, 2'b10, 1'b0, 1'b0};
    tbl[12] = '{8'h1, 16'h3, 8'h1, 8'h2, 1'b0, 2'b11, 1'b0, 1'b0};
    tbl[13] = '{8'h2, 16'h8, 8'h0, 8'h0, 1'b0, 2'b10, 1'b0, 1'b0};

    // Reset holds every output low even with a driver active.
    rst_n = 1'b0;
    set_in(8'h1, 16'h2, 8'h1, 8'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs", 32'(dut_vec()), 32'd0);
`ifdef USB_CONTENTION_LOG_EN
      check("reset_log", {bus.contention_cnt_o, 16'(bus.contention_port_o)}, 32'd0);
`endif
      $display("reset cycle %0d: outputs %0h", i, dut_vec());
    end

    // Attach with a D+ pullup on port 1.
    do_reset();
    set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b0);
    cnt = 0; idx = -1;
    for (int k = 1; k <= 110; k++) begin
      step();
      if (bus.attach_evt_o === 1'b1) begin cnt++; if (idx < 0) idx = k; end
    end
    check("attach_pulse_count", 32'(cnt), 32'd1);
    check("attach_pulse_cycle", 32'(idx), 32'd101);
    check("attach_line", 32'(bus.line_o), 32'h2);
    check("attach_connected", 32'(bus.connected_o), 32'd1);
    check("attach_full_speed", 32'(bus.full_speed_o), 32'd1);
    $display("attach: pulses %0d at cycle %0d", cnt, idx);

    // One cycle short of a bus reset.
    set_in(8'h1, 16'h0, 8'h2, 8'h0, 1'b0);
    cnt = 0;
    for (int k = 1; k <= RST - 1; k++) begin step(); if (bus.bus_reset_o === 1'b1) cnt++; end
    set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b0);
    for (int k = 0; k < 5; k++) begin step(); if (bus.bus_reset_o === 1'b1) cnt++; end
    check("bus_reset_short", 32'(cnt), 32'd0);
    $display("bus reset 479 cycles: pulses %0d", cnt);

    // Full-length driven SE0 then release.
    set_in(8'h1, 16'h0, 8'h2, 8'h0, 1'b0);
    cnt = 0; idx = -1;
    for (int k = 1; k <= RST + 5; k++) begin
      if (k == RST + 1) set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b0);
      step();
      if (bus.bus_reset_o === 1'b1) begin cnt++; if (idx < 0) idx = k; end
    end
    check("bus_reset_count", 32'(cnt), 32'd1);
    check("bus_reset_cycle", 32'(idx), 32'(RST + 1));
    check("bus_reset_connected", 32'(bus.connected_o), 32'd1);
    check("bus_reset_release_line", 32'(bus.line_o), 32'h2);
    $display("bus reset 480 cycles: pulses %0d at cycle %0d", cnt, idx);

    // Pullup removed: detach after the debounce.
    set_in(8'h0, 16'h0, 8'h0, 8'h0, 1'b0);
    cnt = 0; idx = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (bus.detach_evt_o === 1'b1) begin cnt++; if (idx < 0) idx = k; end
    end
    check("detach_count", 32'(cnt), 32'd1);
    check("detach_cycle", 32'(idx), 32'(DET + 1));
    check("detach_connected", 32'(bus.connected_o), 32'd0);
    check("detach_full_speed", 32'(bus.full_speed_o), 32'd0);
    $display("detach: pulses %0d at cycle %0d", cnt, idx);

    // Glitch in the middle of an attach debounce.
    set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 52; k++) begin step(); if (bus.attach_evt_o === 1'b1) cnt++; end
    check("glitch_no_early_attach", 32'(cnt), 32'd0);
    set_in(8'h1, 16'h0, 8'h2, 8'h0, 1'b0);
    step();
    set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b0);
    idx = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (bus.attach_evt_o === 1'b1) begin idx = k; break; end
    end
    check("glitch_fresh_attach", 32'(idx), 32'd101);
    $display("glitch: attach %0d cycles after glitch", idx);

    // Contention is sticky and wins over a simultaneous clear.
    set_in(8'h3, 16'h9, 8'h2, 8'h0, 1'b0);
    step();
    check("cont_line", 32'(bus.line_o), 32'h0);
    check("cont_set", 32'(bus.contention_o), 32'd1);
    set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    check("cont_held", 32'(bus.contention_o), 32'd1);
    set_in(8'h3, 16'h9, 8'h2, 8'h0, 1'b1);
    step();
    check("cont_clear_vs_set", 32'(bus.contention_o), 32'd1);
    set_in(8'h0, 16'h0, 8'h2, 8'h0, 1'b1);
    step();
    check("cont_cleared", 32'(bus.contention_o), 32'd0);
    $display("contention sequence: final flag %0b", bus.contention_o);

    // Resolution vector table.
    do_reset();
    foreach (tbl[i]) begin
      set_in(tbl[i].en, tbl[i].data, tbl[i].dp, tbl[i].dm, tbl[i].clr);
      step();
      check($sformatf("vec%0d", i), {29'd0, bus.line_o, bus.contention_o, bus.config_err_o},
            {29'd0, tbl[i].line, tbl[i].cont, tbl[i].cfg});
      $display("vec %0d: en=%0h line=%0b cont=%0b cfg=%0b", i, tbl[i].en,
               bus.line_o, bus.contention_o, bus.config_err_o);
    end

`ifdef USB_CONTENTION_LOG_EN
    do_reset();
    set_in(8'hC, 16'h0, 8'h0, 8'h0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    check("log_cnt", 32'(bus.contention_cnt_o), 32'd3);
    check("log_port", 32'(bus.contention_port_o), 32'd2);
    set_in(8'h0, 16'h0, 8'h0, 8'h0, 1'b1);
    step();
    check("log_clear", {bus.contention_cnt_o, 16'(bus.contention_port_o)}, 32'd0);
    $display("contention log: cleared to %0d", bus.contention_cnt_o);
`endif

    // Random segments against the model.
    do_reset();
    for (int s = 0; s < 40; s++) begin
      int mode, len, p;
      bit clr_r;
      mode = $urandom_range(0, 5);
      len  = $urandom_range(1, 600);
      p    = $urandom_range(0, NP - 1);
      cnt2 = 0;
      for (int k = 0; k < len; k++) begin
        clr_r = ($urandom_range(0, 49) == 0);
        en_r = 8'h0; dat_r = 16'h0; dp_r = 8'h0; dm_r = 8'h0;
        case (mode)
          0: dp_r = 8'(1 << p);
          1: dm_r = 8'(1 << p);
          2: ;
          3: begin en_r = 8'(1 << p); dp_r = 8'(1 << p); end
          4: begin
            en_r = 8'($urandom); dat_r = 16'($urandom);
            dp_r = 8'($urandom); dm_r = 8'($urandom);
          end
          default: begin en_r = 8'(1 << p); dat_r = 16'($urandom); end
        endcase
        set_in(en_r, dat_r, dp_r, dm_r, clr_r);
        rst_n = ($urandom_range(0, 1999) != 0);
        step();
        check("random_outputs", 32'(dut_vec()), 32'(model_vec()));
`ifdef USB_CONTENTION_LOG_EN
        check("random_log", {bus.contention_cnt_o, 16'(bus.contention_port_o)},
              {16'(m_ccnt), 16'(m_cport)});
`endif
        if (dut_vec() !== model_vec()) cnt2++;
      end
      rst_n = 1'b1;
      $display("segment %0d: mode %0d len %0d differing cycles %0d", s, mode, len, cnt2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
